// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef logic [1:0] fetch_state_e;

  localparam fetch_state_e S_IDLE  = 2'd0;
  localparam fetch_state_e S_RUN   = 2'd1;
  localparam fetch_state_e S_DRAIN = 2'd2;
  localparam fetch_state_e S_HALT  = 2'd3;

  localparam int INST_BYTES = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  function automatic logic is_fetching(input fetch_state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from the array.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != '0);
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, credit-limited imem requests, response queue and
// redirect handling that flushes the queue and discards stale responses.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     nrst,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [XLEN-1:0]          req_addr,
  input  logic                     resp_valid,
  input  logic [ILEN-1:0]          resp_data,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     halt,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [ILEN-1:0]          inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XLEN + ILEN;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic            misalign_err_reg;

  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [AW-1:0]   tag_wr_reg;
  logic [AW-1:0]   tag_rd_reg;

  logic            issue;
  logic            resp_ok;
  logic            resp_drop;
  logic            resp_keep;
  logic [CW:0]     credit_sum;
  logic [EW-1:0]   fifo_dout;

  // Queued entries plus in-flight requests never exceed DEPTH, so pushes cannot overflow.
  assign credit_sum = {1'b0, occupancy} + {1'b0, outstanding_reg};
  assign req_valid  = is_fetching(state_reg) && !halt && !redirect && (credit_sum < CREDITS);
  assign req_addr   = pc_reg;
  assign issue      = req_valid && req_ready;

  assign resp_ok   = resp_valid && (outstanding_reg != '0);
  assign resp_drop = resp_ok && (drop_cnt_reg != '0);
  assign resp_keep = resp_ok && !resp_drop && !redirect;

  assign outstanding_next = outstanding_reg + CW'(issue) - CW'(resp_ok);

  always_comb begin
    drop_cnt_next = drop_cnt_reg - CW'(resp_drop);
    pc_next       = pc_reg;
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_next = outstanding_next;
      pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      pc_next = pc_reg + XLEN'(INST_BYTES);
    end
  end

  always_comb begin
    state_next = S_IDLE;
    if (state_reg != S_IDLE) begin
      if (halt)                      state_next = S_HALT;
      else if (drop_cnt_next != '0)  state_next = S_DRAIN;
      else                           state_next = S_RUN;
    end else begin
      state_next = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg        <= S_IDLE;
      pc_reg           <= RESET_PC;
      outstanding_reg  <= '0;
      drop_cnt_reg     <= '0;
      misalign_err_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      outstanding_reg  <= outstanding_next;
      drop_cnt_reg     <= drop_cnt_next;
      misalign_err_reg <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end

  // Tag ring holds the PCs of in-flight requests whose responses will be kept.
  always_ff @(posedge clk) begin
    if (!nrst || redirect) begin
      tag_wr_reg <= '0;
      tag_rd_reg <= '0;
    end else begin
      if (issue)     tag_wr_reg <= tag_wr_reg + AW'(1);
      if (resp_keep) tag_rd_reg <= tag_rd_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_reg] <= pc_reg;
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .nrst  (nrst),
    .push  (resp_keep),
    .pop   (inst_valid && inst_ready && !redirect),
    .flush (redirect),
    .din   ({tag_mem[tag_rd_reg], resp_data}),
    .dout  (fifo_dout),
    .count (occupancy)
  );

  assign inst_valid   = (occupancy != '0);
  assign inst_pc      = fifo_dout[ILEN +: XLEN];
  assign inst_data    = fifo_dout[ILEN-1:0];
  assign misalign_err = misalign_err_reg;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: imem model with programmable latency, scoreboard
// of expected {pc, instruction} pairs checked by an independent monitor.
module tb_fetch_queue_unit;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              nrst;
  logic              req_valid, req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              resp_valid;
  logic [ILEN-1:0]   resp_data;
  logic              redirect, halt;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid, inst_ready;
  logic [ILEN-1:0]   inst_data;
  logic [XLEN-1:0]   inst_pc;
  logic              misalign_err;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .misalign_err(misalign_err), .occupancy(occupancy)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        sb_q[$];
  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int grant_limit = 0;
  int lat = 1;
  int cyc = 0;
  int base;

  // Memory contents: each word is the bitwise complement of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sb_q.push_back('{pc, mem_word(pc)});
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check("wait_acc", acc_cnt, target);
  endtask

  // imem model: in-order responses 'lat' cycles after acceptance, grants up to grant_limit.
  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    req_ready  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        resp_valid = 1'b0;
      end
      #1;
      req_ready = (acc_cnt < grant_limit);
      if (!nrst) begin
        pend_q.delete();
      end else if (req_valid && req_ready) begin
        pend_q.push_back('{req_addr, cyc + lat});
        req_log.push_back(req_addr);
        acc_cnt++;
      end
    end
  end

  // Monitor: every dequeue handshake is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (nrst && inst_valid && inst_ready && !redirect) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL deq_unexpected: got pc %h data %h, expected nothing", inst_pc, inst_data);
        end else begin
          e = sb_q.pop_front();
          if (inst_pc !== e.pc || inst_data !== e.data) begin
            errors++;
            $display("FAIL deq: got pc %h data %h expected pc %h data %h",
                     inst_pc, inst_data, e.pc, e.data);
          end else begin
            $display("ok   deq: pc %h data %h", inst_pc, inst_data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk); #2;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_req_addr", req_addr, 32'h0);

    // 1: in-order stream with 1-cycle latency
    @(negedge clk);
    nrst = 1'b1; grant_limit = 4;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    wait_acc(4, 20);
    repeat (6) @(negedge clk); #2;
    check("t1_addr0", req_log[0], 32'h0);
    check("t1_addr1", req_log[1], 32'h4);
    check("t1_addr2", req_log[2], 32'h8);
    check("t1_addr3", req_log[3], 32'hC);
    check("t1_sb_empty", sb_q.size(), 0);

    // 2: decode stalled, credits stop issue at DEPTH entries
    @(negedge clk);
    inst_ready = 1'b0; grant_limit = acc_cnt + 4;
    push_exp(32'h10); push_exp(32'h14); push_exp(32'h18); push_exp(32'h1C);
    repeat (12) @(negedge clk); #2;
    check("t2_req_valid", 32'(req_valid), 32'd0);
    check("t2_occupancy", 32'(occupancy), 32'd4);
    check("t2_accepted", acc_cnt, 8);
    check("t2_req_addr", req_addr, 32'h20);
    @(negedge clk);
    inst_ready = 1'b1;
    repeat (8) @(negedge clk); #2;
    check("t2_drained", 32'(occupancy), 32'd0);

    // 3: redirect with three requests in flight, latency 4
    @(negedge clk);
    lat = 4; grant_limit = acc_cnt + 3;
    wait_acc(11, 20);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h3E8; grant_limit = acc_cnt + 2;
    push_exp(32'h3E8); push_exp(32'h3EC);
    @(negedge clk);
    redirect = 1'b0; #2;
    check("t3_misalign", 32'(misalign_err), 32'd0);
    check("t3_req_addr", req_addr, 32'h3E8);
    check("t3_occ_flushed", 32'(occupancy), 32'd0);
    repeat (16) @(negedge clk); #2;
    check("t3_accepted", acc_cnt, 13);
    check("t3_sb_empty", sb_q.size(), 0);

    // 4: misaligned redirect target
    @(negedge clk);
    lat = 1; redirect = 1'b1; redirect_pc = 32'h7D2;
    @(negedge clk);
    redirect = 1'b0; #2;
    check("t4_misalign_pulse", 32'(misalign_err), 32'd1);
    check("t4_req_addr", req_addr, 32'h7D0);
    @(negedge clk); #2;
    check("t4_misalign_clear", 32'(misalign_err), 32'd0);
    @(negedge clk);
    base = acc_cnt; grant_limit = acc_cnt + 1;
    push_exp(32'h7D0);
    repeat (5) @(negedge clk); #2;
    check("t4_addr", req_log[base], 32'h7D0);

    // 5: halt mid-stream keeps pending responses, resume continues pc
    @(negedge clk);
    inst_ready = 1'b0; lat = 3; base = acc_cnt; grant_limit = base + 2;
    push_exp(32'h7D4); push_exp(32'h7D8); push_exp(32'h7DC); push_exp(32'h7E0);
    push_exp(32'h7E4); push_exp(32'h7E8); push_exp(32'h7EC);
    wait_acc(base + 2, 20);
    @(negedge clk);
    halt = 1'b1; grant_limit = acc_cnt + 5;
    repeat (6) @(negedge clk); #2;
    check("t5_no_issue", acc_cnt, base + 2);
    check("t5_occupancy", 32'(occupancy), 32'd2);
    check("t5_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk);
    halt = 1'b0; inst_ready = 1'b1;
    repeat (25) @(negedge clk); #2;
    check("t5_resume_addr", req_log[base + 2], 32'h7DC);
    check("t5_last_addr", req_log[base + 6], 32'h7EC);
    check("t5_sb_empty", sb_q.size(), 0);

    // 6: pc wrap, then reset mid-stream
    @(negedge clk);
    lat = 1; redirect = 1'b1; redirect_pc = 32'hFFFFFFF8;
    base = acc_cnt; grant_limit = base + 3;
    push_exp(32'hFFFFFFF8); push_exp(32'hFFFFFFFC); push_exp(32'h0);
    @(negedge clk);
    redirect = 1'b0;
    repeat (8) @(negedge clk); #2;
    check("t6_addr_fc", req_log[base + 1], 32'hFFFFFFFC);
    check("t6_addr_wrap", req_log[base + 2], 32'h0);
    check("t6_sb_empty", sb_q.size(), 0);
    @(negedge clk);
    inst_ready = 1'b0; grant_limit = acc_cnt + 100;
    repeat (8) @(negedge clk); #2;
    check("t6_pre_rst_occ", 32'(occupancy), 32'd4);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk); #2;
    check("t6_rst_req_valid", 32'(req_valid), 32'd0);
    check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_occupancy", 32'(occupancy), 32'd0);
    check("t6_rst_req_addr", req_addr, 32'h0);
    check("t6_rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    nrst = 1'b1; grant_limit = acc_cnt;
    repeat (3) @(negedge clk); #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
